// File: rtl/coeff_pingpong_buffer.sv
// Purpose: ping-pong assembler that collects indexed JPEG coefficients into 64-entry blocks.
// Latency: a block is presented on block_valid the cycle after its closing block_done edge.
// Backpressure: in_ready drops while both banks are full; anything offered then is dropped and flags err_overrun.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   coeff_in          signed coefficient value (WIDTH bits)
//   coeff_index       coefficient position, zigzag order when ZIGZAG=1, natural order otherwise
//   coeff_valid       write strobe, taken only while in_ready=1
//   block_done        closes the fill bank, taken only while in_ready=1
//   block_tag_in      tag captured with block_done
//   in_ready          a fill bank is available
//   block_out_flat    presented block in natural order, entry k at [k*WIDTH +: WIDTH]
//   block_tag         tag of the presented block
//   block_valid       a full block is presented
//   block_ready       downstream takes the presented block
//   err_overrun       sticky: a write or close was offered while in_ready=0
module coeff_pingpong_buffer #(
    parameter int WIDTH  = 16,
    parameter int TAG_W  = 2,
    parameter int ZIGZAG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] coeff_in,
    input  logic [5:0]              coeff_index,
    input  logic                    coeff_valid,
    input  logic                    block_done,
    input  logic [TAG_W-1:0]        block_tag_in,
    output logic                    in_ready,
    output logic [WIDTH*64-1:0]     block_out_flat,
    output logic [TAG_W-1:0]        block_tag,
    output logic                    block_valid,
    input  logic                    block_ready,
    output logic                    err_overrun
);

    // Zigzag scan position -> natural (raster) position.
    localparam logic [5:0] ZZ2NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Coefficient storage is never reset: the written-bitmaps mask stale
    // contents, which is what gives the implicit zero-fill.
    logic [WIDTH-1:0] mem    [2][64];
    logic [63:0]      bitmap [2];
    logic [TAG_W-1:0] tag_q  [2];

    logic       wp;       // bank currently filling
    logic       rp;       // oldest full bank, the one presented
    logic [1:0] count;    // number of full banks, 0..2
    logic       err_q;

    logic       wr_en;
    logic       close_en;
    logic       accept_en;
    logic [5:0] wr_addr;

    // in_ready and block_valid come from registered state only, so there is
    // no combinational path from block_ready back to in_ready.
    assign in_ready    = (count != 2'd2);
    assign block_valid = (count != 2'd0);

    assign wr_en     = coeff_valid && in_ready;
    assign close_en  = block_done  && in_ready;
    assign accept_en = block_valid && block_ready;

    assign wr_addr = (ZIGZAG != 0) ? ZZ2NAT[coeff_index] : coeff_index;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp][wr_addr] <= coeff_in;
        end
    end

    // When count is 1 the filling and presented banks differ; when count is
    // 0 or 2 either writes or accepts are impossible, so the set and the
    // clear below never target the same bank in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap[0] <= '0;
            bitmap[1] <= '0;
        end else begin
            if (wr_en) begin
                bitmap[wp][wr_addr] <= 1'b1;
            end
            if (accept_en) begin
                bitmap[rp] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q[0] <= '0;
            tag_q[1] <= '0;
        end else if (close_en) begin
            tag_q[wp] <= block_tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (close_en) begin
                wp <= ~wp;
            end
            if (accept_en) begin
                rp <= ~rp;
            end
            unique case ({close_en, accept_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((coeff_valid || block_done) && !in_ready) begin
            err_q <= 1'b1;
        end
    end

    assign err_overrun = err_q;
    assign block_tag   = tag_q[rp];

    for (genvar k = 0; k < 64; k++) begin : g_out
        assign block_out_flat[k*WIDTH +: WIDTH] = bitmap[rp][k] ? mem[rp][k] : '0;
    end

endmodule

// File: tb/tb_coeff_pingpong_buffer.sv
module tb_coeff_pingpong_buffer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]   cv = '0;
    logic [1:0]   bd = '0;
    logic [1:0]   br = '0;
    logic [5:0]   ci   [2];
    logic [W-1:0] cdat [2];
    logic [1:0]   tg   [2];

    logic [W*64-1:0] flat [2];
    logic [1:0]      btag [2];
    logic [1:0]      irdy;
    logic [1:0]      bval;
    logic [1:0]      err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    coeff_pingpong_buffer #(.WIDTH(W), .TAG_W(2), .ZIGZAG(1)) dut_zz (
        .clk(clk), .rst_n(rst_n),
        .coeff_in(cdat[0]), .coeff_index(ci[0]), .coeff_valid(cv[0]),
        .block_done(bd[0]), .block_tag_in(tg[0]), .in_ready(irdy[0]),
        .block_out_flat(flat[0]), .block_tag(btag[0]), .block_valid(bval[0]),
        .block_ready(br[0]), .err_overrun(err[0])
    );

    coeff_pingpong_buffer #(.WIDTH(W), .TAG_W(2), .ZIGZAG(0)) dut_nat (
        .clk(clk), .rst_n(rst_n),
        .coeff_in(cdat[1]), .coeff_index(ci[1]), .coeff_valid(cv[1]),
        .block_done(bd[1]), .block_tag_in(tg[1]), .in_ready(irdy[1]),
        .block_out_flat(flat[1]), .block_tag(btag[1]), .block_valid(bval[1]),
        .block_ready(br[1]), .err_overrun(err[1])
    );

    // ---------------- reference model ----------------
    // Each instance is a 2-deep queue of finished blocks plus one block
    // being assembled; a fresh block starts as all zeros.
    int           zz [64];
    logic [1023:0] mq  [2][2];
    logic [1:0]    mt  [2][2];
    int            mcnt [2];
    logic [1023:0] mfill [2];
    logic          merr [2];

    initial begin : build_zz
        int k;
        int lo;
        int hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy;
        bit vld;
        int a;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i] = 0; mfill[i] = '0; merr[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rdy = (mcnt[i] < 2);
                vld = (mcnt[i] > 0);
                if ((cv[i] || bd[i]) && !rdy) merr[i] = 1'b1;
                if (cv[i] && rdy) begin
                    a = (i == 0) ? zz[ci[i]] : int'(ci[i]);
                    mfill[i][a*W +: W] = cdat[i];
                end
                if (vld && br[i]) begin
                    mq[i][0] = mq[i][1]; mt[i][0] = mt[i][1]; mcnt[i]--;
                end
                if (bd[i] && rdy) begin
                    mq[i][mcnt[i]] = mfill[i]; mt[i][mcnt[i]] = tg[i]; mcnt[i]++;
                    mfill[i] = '0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int inst, input logic [1023:0] act, input logic [1023:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, inst, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, inst, act, exp);
        end
    endtask

    function automatic logic [15:0] ent(input int i, input int k);
        return flat[i][k*W +: W];
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk16("block_valid", i, {15'd0, bval[i]}, {15'd0, mcnt[i] > 0});
                chk16("in_ready",    i, {15'd0, irdy[i]}, {15'd0, mcnt[i] < 2});
                chk16("err_overrun", i, {15'd0, err[i]},  {15'd0, merr[i]});
                if (mcnt[i] > 0) begin
                    chk("block_out", i, flat[i], mq[i][0]);
                    chk16("block_tag", i, {14'd0, btag[i]}, {14'd0, mt[i][0]});
                end
            end
        end
    end

    // One cycle on instance i; the other instance idles with its inputs low.
    task automatic cyc(input int i, input bit v, input int idx, input int dat,
                       input bit d, input int t, input bit r);
        @(negedge clk);
        cv = '0; bd = '0; br = '0;
        cv[i]   = v;
        ci[i]   = idx[5:0];
        cdat[i] = dat[15:0];
        bd[i]   = d;
        tg[i]   = t[1:0];
        br[i]   = r;
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin : stim
        for (int i = 0; i < 2; i++) begin ci[i] = '0; cdat[i] = '0; tg[i] = '0; end

        chk16("zz_pin2",  0, zz[2][15:0],  16'd8);
        chk16("zz_pin3",  0, zz[3][15:0],  16'd16);
        chk16("zz_pin15", 0, zz[15][15:0], 16'd5);
        chk16("zz_pin63", 0, zz[63][15:0], 16'd63);

        // reset state
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk16("rst_valid", i, {15'd0, bval[i]}, 16'd0);
            chk16("rst_ready", i, {15'd0, irdy[i]}, 16'd1);
            chk16("rst_err",   i, {15'd0, err[i]},  16'd0);
            chk("rst_flat",    i, flat[i], '0);
            chk16("rst_tag",   i, {14'd0, btag[i]}, 16'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        // ---- ZIGZAG=1 instance ----
        cyc(0, 1, 0, 100, 0, 0, 0);
        cyc(0, 1, 2, -5,  0, 0, 0);
        cyc(0, 1, 63, 7,  0, 0, 0);
        chk16("valid_before_close", 0, {15'd0, bval[0]}, 16'd0);
        cyc(0, 0, 0, 0, 1, 2, 0);
        chk16("b1_valid", 0, {15'd0, bval[0]}, 16'd1);
        chk16("b1_nat0",  0, ent(0, 0),  16'd100);
        chk16("b1_nat8",  0, ent(0, 8),  16'hFFFB);
        chk16("b1_nat63", 0, ent(0, 63), 16'd7);
        chk16("b1_nat1",  0, ent(0, 1),  16'd0);
        chk16("b1_tag",   0, {14'd0, btag[0]}, 16'd2);

        // second block queued behind the first
        cyc(0, 1, 1, 11, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk16("full_ready", 0, {15'd0, irdy[0]}, 16'd0);
        chk16("hold_nat0",  0, ent(0, 0), 16'd100);

        // overrun while both banks are full
        cyc(0, 1, 5, 77, 1, 3, 0);
        chk16("ovr_err",   0, {15'd0, err[0]}, 16'd1);
        chk16("ovr_nat0",  0, ent(0, 0), 16'd100);

        cyc(0, 0, 0, 0, 0, 0, 1);
        chk16("b2_valid", 0, {15'd0, bval[0]}, 16'd1);
        chk16("b2_nat1",  0, ent(0, 1), 16'd11);
        chk16("b2_nat0",  0, ent(0, 0), 16'd0);
        chk16("b2_nat2",  0, ent(0, 2), 16'd0);
        chk16("b2_tag",   0, {14'd0, btag[0]}, 16'd1);
        chk16("b2_ready", 0, {15'd0, irdy[0]}, 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk16("drain_valid", 0, {15'd0, bval[0]}, 16'd0);
        chk16("drain_err",   0, {15'd0, err[0]},  16'd1);

        // write and close in the same cycle
        cyc(0, 1, 0, 33, 1, 3, 0);
        chk16("same_nat0", 0, ent(0, 0), 16'd33);
        chk16("same_tag",  0, {14'd0, btag[0]}, 16'd3);

        // close an empty block while accepting the presented one
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk16("sim_valid", 0, {15'd0, bval[0]}, 16'd1);
        chk("sim_flat",    0, flat[0], '0);
        chk16("sim_tag",   0, {14'd0, btag[0]}, 16'd0);

        // full zigzag sweep
        for (int k = 0; k < 64; k++) cyc(0, 1, k, k * 3 + 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk16("sweep_nat8",  0, ent(0, 8),  16'd7);
        chk16("sweep_nat5",  0, ent(0, 5),  16'd46);
        chk16("sweep_nat63", 0, ent(0, 63), 16'd190);

        // reset mid-operation
        cyc(0, 1, 4, 5, 0, 0, 0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk16("mid_rst_valid", 0, {15'd0, bval[0]}, 16'd0);
        chk16("mid_rst_err",   0, {15'd0, err[0]},  16'd0);
        chk16("mid_rst_ready", 0, {15'd0, irdy[0]}, 16'd1);
        @(negedge clk); rst_n = 1'b1;

        // ---- ZIGZAG=0 instance ----
        cyc(1, 1, 8, -1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1, 1);
        chk16("n_valid", 1, {15'd0, bval[1]}, 16'd1);
        chk16("n_nat8",  1, ent(1, 8), 16'hFFFF);
        chk16("n_tag",   1, {14'd0, btag[1]}, 16'd1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk16("n_accept", 1, {15'd0, bval[1]}, 16'd0);

        // zero-fill across blocks, duplicate index last-write-wins
        cyc(1, 1, 5, 9, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk16("za_nat5", 1, ent(1, 5), 16'd9);
        cyc(1, 1, 6, 3, 0, 0, 1);
        cyc(1, 1, 6, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 2, 0);
        chk16("zb_nat5", 1, ent(1, 5), 16'd0);
        chk16("zb_nat6", 1, ent(1, 6), 16'd1);
        chk16("zb_tag",  1, {14'd0, btag[1]}, 16'd2);

        cyc(1, 0, 0, 0, 1, 3, 1);
        chk("empty_flat", 1, flat[1], '0);
        chk16("empty_tag", 1, {14'd0, btag[1]}, 16'd3);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk16("n_drain", 1, {15'd0, bval[1]}, 16'd0);
        chk16("n_err",   1, {15'd0, err[1]},  16'd0);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coeff_pingpong_buffer.md
Name: coeff_pingpong_buffer

Overview:
- Next-generation coefficient block assembler for the JPEG decoder.
- Sits between the Huffman/RLE decoder and dequant/IDCT.
- Collects indexed coefficients into one of two 64-entry banks (ping-pong), so a new block can fill while the previous block waits for downstream.
- Adds optional zigzag-to-natural reordering, implicit zero-fill of unwritten positions, a per-block tag, and sticky overrun detection.

Parameters:
- WIDTH, 16, coefficient width in bits (signed).
- TAG_W, 2, width of the per-block tag (component ID).
- ZIGZAG, 1, 1 = coeff_index is in zigzag order and is mapped to natural (raster) order; 0 = coeff_index is already natural order.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- coeff_in  input  WIDTH  signed coefficient value.
- coeff_index  input  6  coefficient position (zigzag or natural, per ZIGZAG).
- coeff_valid  input  1  write strobe; accepted only when in_ready=1.
- block_done  input  1  closes the current fill bank; accepted only when in_ready=1.
- block_tag_in  input  TAG_W  tag captured with block_done.
- in_ready  output  1  fill bank available for writes.
- block_out_flat  output  WIDTH*64  natural-order block; entry k is at [k*WIDTH +: WIDTH].
- block_tag  output  TAG_W  tag of the presented block.
- block_valid  output  1  presented block is valid.
- block_ready  input  1  downstream accepts the block.
- err_overrun  output  1  sticky: coeff_valid or block_done was asserted while in_ready=0.

Behaviour:
- Reset (async, rst_n low): both banks EMPTY; both written-bitmaps cleared; wp=0, rp=0, count=0; block_valid=0, in_ready=1, err_overrun=0, block_tag=0. block_out_flat is all zeros, masked by the cleared bitmaps. Bank data RAM is not reset.
- Bank state: each bank is FILLING (owned by wp) or FULL (queued for output); count = number of FULL banks (0..2).
- in_ready = (count<2). It is a registered-state function only and never combinationally depends on block_ready.
- Write (coeff_valid && in_ready):
  - addr = ZIGZAG ? zz2nat(coeff_index) : coeff_index.
  - mem[wp][addr] <= coeff_in; bitmap[wp][addr] <= 1.
  - Duplicate index within a block: last write wins.
- Close (block_done && in_ready):
  - Bank wp becomes FULL; tag[wp] <= block_tag_in; wp toggles; count increments.
  - A coeff_valid in the same cycle is written into the closing bank and included in that block.
  - block_done with no prior writes produces an all-zero block.
- Output: block_valid = (count>0).
  - block_out_flat[k] = bitmap[rp][k] ? mem[rp][k] : 0; block_tag = tag[rp].
  - Output is stable while block_valid=1 and block_ready=0.
- Accept (block_valid && block_ready): bitmap[rp] cleared; rp toggles; count decrements. The next FULL bank, if any, is presented the following cycle (1-cycle gap-free back-to-back).
- Simultaneous close and accept: count unchanged, pointers both advance. With count==2, close is refused that cycle (in_ready=0); in_ready rises the cycle after the accept.
- Latency: from the closing block_done edge, block_valid rises the next cycle when count was 0.
- Overrun: coeff_valid or block_done with in_ready=0 is dropped, and err_overrun <= 1 until reset.
- Zigzag table (zz2nat) starts 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5, ... and ends 63. It is a standard JPEG table implemented as a 64-entry constant ROM.
- Reset mid-operation: all queued and partially filled blocks are discarded; state returns to the reset values above.

Test Plan:
- ZIGZAG=1: write index 0=100, 2=-5, 63=7, then block_done with tag=2 -> next cycle block_valid=1; natural[0]=100, natural[8]=-5, natural[63]=7, all other entries 0, block_tag=2.
- Hold block_ready=0, then fill and close a second block -> count=2, in_ready=0; first block output unchanged. Pulse block_ready -> second block presented the next cycle; in_ready=1 the cycle after the accept.
- Zero-fill across blocks: block A writes natural[5]=9; block B writes only natural[6]=1 -> block B shows natural[5]=0, natural[6]=1.
- Same-cycle coeff_valid (index 0=33) and block_done -> the closed block contains 33 at natural[0].
- While count=2, drive coeff_valid=1 -> the write is dropped (no bank changes) and err_overrun=1 remains set after the queue drains; asserting rst_n=0 clears it and also clears block_valid.
- ZIGZAG=0: write index 8=-1, close, hold block_ready=1 continuously -> block accepted in 1 cycle; natural[8]=-1; block_done empty block -> all-zero output.
